// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 width codes, FSM state and port-owner types for the data-memory arbiter
package dmem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic {IDLE, ACCESS} state_t;
  typedef enum logic {OWN_C, OWN_L} owner_t;
endpackage

// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: core (c_*) and loader (l_*) request/response ports plus the single memory port (mem_*); slave = arbiter side
interface dmem_port_arbiter_if #(parameter int AW = 10, parameter int DW = 32);
  logic          c_req, c_we, c_ack, c_err;
  logic [2:0]    c_funct3;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_rdata;
  logic          l_req, l_we, l_ack, l_err, l_lock;
  logic [2:0]    l_funct3;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata, l_rdata;
  logic          mem_we;
  logic [2:0]    mem_funct3;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  modport slave (
    input  c_req, c_we, c_funct3, c_addr, c_wdata,
    input  l_req, l_we, l_funct3, l_addr, l_wdata, l_lock,
    input  mem_rdata,
    output c_ack, c_err, c_rdata, l_ack, l_err, l_rdata,
    output mem_we, mem_funct3, mem_addr, mem_wdata
  );
  modport master (
    output c_req, c_we, c_funct3, c_addr, c_wdata,
    output l_req, l_we, l_funct3, l_addr, l_wdata, l_lock,
    output mem_rdata,
    input  c_ack, c_err, c_rdata, l_ack, l_err, l_rdata,
    input  mem_we, mem_funct3, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_access_check.sv
// dmem_access_check: combinational legality of (we, funct3, addr): valid width code, natural alignment, no run past the top byte
module dmem_access_check
  import dmem_pkg::*;
#(parameter int AW = 10)
(
  input  logic          we,
  input  logic [2:0]    funct3,
  input  logic [AW-1:0] addr,
  output logic          legal
);
  logic [AW:0] last;
  logic        code_ok;
  always_comb begin
    code_ok = funct3 inside {F3_B, F3_H, F3_W} || (!we && funct3 inside {F3_BU, F3_HU});
    last    = {1'b0, addr} + (AW+1)'(funct3[1] ? 3 : funct3[0] ? 1 : 0);
    legal   = code_ok && !(funct3[0] && addr[0]) && !(funct3[1] && addr[1:0] != 2'b00) && !last[AW];
  end
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data-memory port between core and loader via bus (c_*, l_*, mem_*); clk rising edge, rst async active-high
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 8
)
(
  input logic           clk,
  input logic           rst,
  dmem_port_arbiter_if.slave bus
);
  localparam int LW = $clog2(MAX_LOCK + 1);
  state_t        state, state_n;
  owner_t        rr_ptr, cmd_owner, win;
  logic          grant, keep_l, sel_l, acc;
  logic          chk_we, chk_legal;
  logic [2:0]    chk_funct3;
  logic [AW-1:0] chk_addr;
  logic [DW-1:0] chk_wdata;
  logic          cmd_we, cmd_legal;
  logic [2:0]    cmd_funct3;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata, rd;
  logic [LW-1:0] lock_cnt;
  always_comb begin
    keep_l     = cmd_owner == OWN_L && bus.l_lock && lock_cnt < LW'(MAX_LOCK);
    win        = bus.c_req && bus.l_req ? (keep_l ? OWN_L : rr_ptr) : (bus.l_req ? OWN_L : OWN_C);
    sel_l      = win == OWN_L;
    chk_we     = sel_l ? bus.l_we : bus.c_we;
    chk_funct3 = sel_l ? bus.l_funct3 : bus.c_funct3;
    chk_addr   = sel_l ? bus.l_addr : bus.c_addr;
    chk_wdata  = sel_l ? bus.l_wdata : bus.c_wdata;
  end
  dmem_access_check #(.AW(AW)) u_check (
    .we    (chk_we),
    .funct3(chk_funct3),
    .addr  (chk_addr),
    .legal (chk_legal)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_comb begin
    grant          = state == IDLE && (bus.c_req || bus.l_req);
    state_n        = grant ? ACCESS : IDLE;
    acc            = state == ACCESS;
    bus.mem_we     = acc && cmd_we && cmd_legal;
    bus.mem_funct3 = acc ? cmd_funct3 : '0;
    bus.mem_addr   = acc ? cmd_addr : '0;
    bus.mem_wdata  = acc ? cmd_wdata : '0;
    rd             = !cmd_we && cmd_legal ? bus.mem_rdata : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rr_ptr     <= OWN_C;
      cmd_owner  <= OWN_C;
      cmd_we     <= 1'b0;
      cmd_legal  <= 1'b0;
      cmd_funct3 <= '0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      lock_cnt   <= '0;
    end else begin
      if (grant) begin
        cmd_owner  <= win;
        rr_ptr     <= win == OWN_C ? OWN_L : OWN_C;
        cmd_we     <= chk_we;
        cmd_legal  <= chk_legal;
        cmd_funct3 <= chk_funct3;
        cmd_addr   <= chk_addr;
        cmd_wdata  <= chk_wdata;
      end
      lock_cnt <= !bus.l_lock || (grant && win == OWN_C) ? '0 :
                  grant && bus.c_req ? lock_cnt + 1'b1 : lock_cnt;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.c_ack   <= 1'b0;
      bus.c_err   <= 1'b0;
      bus.c_rdata <= '0;
      bus.l_ack   <= 1'b0;
      bus.l_err   <= 1'b0;
      bus.l_rdata <= '0;
    end else begin
      bus.c_ack <= acc && cmd_owner == OWN_C;
      bus.c_err <= acc && cmd_owner == OWN_C && !cmd_legal;
      bus.l_ack <= acc && cmd_owner == OWN_L;
      bus.l_err <= acc && cmd_owner == OWN_L && !cmd_legal;
      if (acc && cmd_owner == OWN_C) bus.c_rdata <= rd;
      if (acc && cmd_owner == OWN_L) bus.l_rdata <= rd;
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: randomized and directed checks of dmem_port_arbiter against a transaction-level reference model
module tb_dmem_port_arbiter;
  import dmem_pkg::*;
  typedef struct packed {logic we; logic [2:0] f3; logic [9:0] addr; logic [31:0] wdata;} cmd_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  int we_cnt = 0;
  bit ref_last = 1'b1;
  logic [7:0] phys [1024] = '{default: 8'h00};
  logic [7:0] refm [1024] = '{default: 8'h00};
  dmem_port_arbiter_if #(.AW(10), .DW(32)) bus();
  dmem_port_arbiter #(.AW(10), .DW(32), .MAX_LOCK(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_read(input logic [7:0] m [1024], input logic [2:0] f3, input logic [9:0] a);
    logic [31:0] v;
    int n;
    n = f3[1:0] == 2'b11 ? 4 : 1 << f3[1:0];
    v = 0;
    for (int i = 0; i < 4; i++) if (i < n) v[8*i +: 8] = m[(int'(a) + i) % 1024];
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction
  always_comb bus.mem_rdata = mem_read(phys, bus.mem_funct3, bus.mem_addr);
  always @(posedge clk)
    if (bus.mem_we)
      for (int i = 0; i < 4; i++)
        if (i < (1 << bus.mem_funct3[1:0])) phys[(int'(bus.mem_addr) + i) % 1024] <= bus.mem_wdata[8*i +: 8];
  always @(negedge clk) if (bus.mem_we) we_cnt <= we_cnt + 1;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic cmd_t mk(input logic we, input logic [2:0] f3, input int addr, input logic [31:0] wdata);
    cmd_t x;
    x.we = we; x.f3 = f3; x.addr = 10'(addr); x.wdata = wdata;
    return x;
  endfunction
  function automatic bit legal_m(input cmd_t x);
    int n;
    bit ok;
    n  = 1 << x.f3[1:0];
    ok = x.we ? x.f3 <= 2 : (x.f3 <= 2 || x.f3 == 4 || x.f3 == 5);
    return ok && int'(x.addr) % n == 0 && int'(x.addr) + n <= 1024;
  endfunction
  task automatic ref_store(input cmd_t x);
    for (int i = 0; i < (1 << x.f3[1:0]); i++) refm[(int'(x.addr) + i) % 1024] = x.wdata[8*i +: 8];
  endtask
  task automatic drive_c(input cmd_t x);
    bus.c_we = x.we; bus.c_funct3 = x.f3; bus.c_addr = x.addr; bus.c_wdata = x.wdata;
  endtask
  task automatic drive_l(input cmd_t x);
    bus.l_we = x.we; bus.l_funct3 = x.f3; bus.l_addr = x.addr; bus.l_wdata = x.wdata;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    bus.c_req = 1'b0; bus.l_req = 1'b0; bus.l_lock = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ref_last = 1'b1;
  endtask
  task automatic serve(input bit port, input cmd_t x, input int at, input logic e, input logic [31:0] rd, input int exp_at);
    string p;
    bit lg;
    p  = port ? "l" : "c";
    lg = legal_m(x);
    check({p, "_latency"}, at, exp_at);
    check({p, "_err"}, 32'(e), 32'(!lg));
    check({p, "_rdata"}, rd, lg && !x.we ? mem_read(refm, x.f3, x.addr) : 32'h0);
    if (lg && x.we) ref_store(x);
    ref_last = port;
  endtask
  task automatic txn(input bit use_c, input bit use_l, input cmd_t cc, input cmd_t lc, output logic [31:0] c_rd, output logic [31:0] l_rd);
    int c_at, l_at, w0, n_st;
    logic c_e, l_e;
    bit c_first;
    c_at = -1; l_at = -1; w0 = we_cnt; c_e = 0; l_e = 0; c_rd = 0; l_rd = 0;
    n_st = int'(use_c && cc.we && legal_m(cc)) + int'(use_l && lc.we && legal_m(lc));
    c_first = use_c && (!use_l || ref_last);
    if (use_c) begin drive_c(cc); bus.c_req = 1'b1; end
    if (use_l) begin drive_l(lc); bus.l_req = 1'b1; end
    for (int cyc = 1; cyc <= 8 && ((use_c && c_at < 0) || (use_l && l_at < 0)); cyc++) begin
      @(posedge clk); #1;
      if (bus.c_ack) begin c_at = cyc; c_e = bus.c_err; c_rd = bus.c_rdata; bus.c_req = 1'b0; end
      if (bus.l_ack) begin l_at = cyc; l_e = bus.l_err; l_rd = bus.l_rdata; bus.l_req = 1'b0; end
    end
    bus.c_req = 1'b0; bus.l_req = 1'b0;
    if (!use_c) check("c_spurious_ack", c_at, -1);
    if (!use_l) check("l_spurious_ack", l_at, -1);
    if (c_first) begin
      serve(0, cc, c_at, c_e, c_rd, 2);
      if (use_l) serve(1, lc, l_at, l_e, l_rd, 4);
    end else begin
      serve(1, lc, l_at, l_e, l_rd, 2);
      if (use_c) serve(0, cc, c_at, c_e, c_rd, 4);
    end
    check("mem_we_pulses", we_cnt - w0, n_st);
  endtask
  function automatic cmd_t rnd_cmd();
    logic [2:0] f3s [7];
    int r;
    cmd_t x;
    f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
    r = $urandom_range(0, 3);
    x.we = 1'($urandom_range(0, 1));
    x.f3 = f3s[$urandom_range(0, 6)];
    x.addr = 10'(r < 2 ? $urandom_range(0, 31) : r == 2 ? $urandom_range(1016, 1023) : $urandom_range(0, 1023));
    x.wdata = $urandom;
    return x;
  endfunction
  initial begin
    cmd_t nop, cc, lc;
    logic [31:0] crd, lrd;
    int nl, l_before_c, l_after_c, w0, at;
    bit c_done;
    logic e;
    nop = '0;
    drive_c(nop); drive_l(nop);
    do_reset;
    check("rst_c_ack", bus.c_ack, 0);
    check("rst_l_ack", bus.l_ack, 0);
    check("rst_c_err", bus.c_err, 0);
    check("rst_c_rdata", bus.c_rdata, 0);
    check("rst_l_rdata", bus.l_rdata, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", 32'(bus.mem_addr), 0);
    check("rst_mem_funct3", 32'(bus.mem_funct3), 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    txn(1, 0, mk(1, F3_W, 4, 32'hDEAD_BEEF), nop, crd, lrd);
    txn(1, 0, mk(0, F3_W, 4, 0), nop, crd, lrd);
    check("lw_deadbeef", crd, 32'hDEAD_BEEF);
    txn(1, 1, mk(0, F3_W, 4, 0), mk(1, F3_H, 8, 32'h1234_ABCD), crd, lrd);
    txn(1, 1, mk(0, F3_HU, 8, 0), mk(0, F3_B, 5, 0), crd, lrd);
    txn(0, 1, nop, mk(0, F3_W, 8, 0), crd, lrd);
    txn(1, 1, mk(0, F3_BU, 7, 0), mk(0, F3_H, 6, 0), crd, lrd);
    txn(1, 0, mk(1, F3_H, 3, 32'h5555), nop, crd, lrd);
    check("ill_sh_rdata", crd, 0);
    txn(1, 0, mk(1, F3_W, 12'h3FE, 32'h7777_7777), nop, crd, lrd);
    txn(1, 0, mk(0, 3'b011, 0, 0), nop, crd, lrd);
    check("ill_f3_rdata", crd, 0);
    txn(1, 0, mk(1, F3_BU, 16, 32'hFF), nop, crd, lrd);
    txn(1, 0, mk(1, F3_B, 12'h3FF, 32'h80), nop, crd, lrd);
    txn(1, 0, mk(0, F3_B, 12'h3FF, 0), nop, crd, lrd);
    check("lb_3ff", crd, 32'hFFFF_FF80);
    txn(1, 0, mk(0, F3_BU, 12'h3FF, 0), nop, crd, lrd);
    check("lbu_3ff", crd, 32'h0000_0080);
    txn(1, 0, mk(0, F3_W, 12'h3FC, 0), nop, crd, lrd);
    do_reset;
    w0 = we_cnt; nl = 0; l_before_c = 0; l_after_c = 0; c_done = 0;
    cc = mk(0, F3_W, 12'h200, 0);
    lc = mk(1, F3_W, 12'h200, $urandom);
    bus.l_lock = 1'b1;
    drive_l(lc); bus.l_req = 1'b1;
    for (int cyc = 1; cyc <= 60 && !(c_done && l_after_c >= 2); cyc++) begin
      @(posedge clk); #1;
      if (bus.l_ack) begin
        check("lock_l_err", bus.l_err, 0);
        ref_store(lc);
        nl++;
        if (c_done) l_after_c++;
        else if (bus.c_req) l_before_c++;
        lc = mk(1, F3_W, 12'h200 + 4*nl, $urandom);
        drive_l(lc);
        if (nl == 1) begin drive_c(cc); bus.c_req = 1'b1; end
      end
      if (bus.c_ack) begin
        check("lock_c_rdata", bus.c_rdata, mem_read(refm, F3_W, 10'h200));
        c_done = 1'b1;
        bus.c_req = 1'b0;
      end
    end
    bus.l_req = 1'b0; bus.l_lock = 1'b0; bus.c_req = 1'b0;
    ref_last = 1'b1;
    check("lock_l_acks_before_c", l_before_c, 8);
    check("lock_c_served", 32'(c_done), 1);
    check("lock_l_resumes", 32'(l_after_c >= 2), 1);
    check("lock_we_pulses", we_cnt - w0, nl);
    txn(1, 0, mk(0, F3_W, 12'h208, 0), nop, crd, lrd);
    do_reset;
    cc = mk(1, F3_W, 12'h100, 32'hCAFE_F00D);
    drive_c(cc); bus.c_req = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_we_before", bus.mem_we, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_we_async", bus.mem_we, 0);
    check("rst_mid_no_ack", bus.c_ack, 0);
    @(posedge clk); #1;
    check("rst_mid_no_ack2", bus.c_ack, 0);
    rst = 1'b0;
    ref_last = 1'b1;
    at = -1; e = 1'b1;
    for (int cyc = 1; cyc <= 6 && at < 0; cyc++) begin
      @(posedge clk); #1;
      if (bus.c_ack) begin at = cyc; e = bus.c_err; bus.c_req = 1'b0; end
    end
    bus.c_req = 1'b0;
    check("rst_reissue_latency", at, 2);
    check("rst_reissue_err", e, 0);
    ref_store(cc);
    ref_last = 1'b0;
    txn(1, 0, mk(0, F3_W, 12'h100, 0), nop, crd, lrd);
    check("rst_reissue_data", crd, 32'hCAFE_F00D);
    for (int k = 0; k < 60; k++) begin
      int mode;
      mode = $urandom_range(0, 2);
      txn(mode != 1, mode != 0, rnd_cmd(), rnd_cmd(), crd, lrd);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
